countdown_timer: RTL and testbench

Down-counting hours:minutes:seconds timer that runs on the 1 Hz clock domain. It is the decrementing counterpart of the clock's up-counting second/minute/hour chain. On each second it borrows from the next higher field, instead of carrying into it. It is loaded with a preset time, started, paused and stopped by the control logic. It reports expiry with a one-cycle `done` pulse and drives the display mux with its current value.

---
 rtl/countdown_timer.sv | 143 ++++++++++++++
 tb/tb_countdown_timer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// countdown_timer: hours:minutes:seconds down-counter clocked at 1 Hz.
// Loaded with a clamped preset, started/paused/stopped by control logic,
// borrows from higher fields on wrap and pulses done once on expiry.
module countdown_timer #(
  parameter int unsigned MAX_SEC  = 59,
  parameter int unsigned MAX_MIN  = 59,
  parameter int unsigned MAX_HOUR = 23
) (
  input  logic       clk_1Hz,
  input  logic       rst,
  input  logic       load,
  input  logic [4:0] load_hour,
  input  logic [5:0] load_min,
  input  logic [5:0] load_sec,
  input  logic       start,
  input  logic       stop,
  output logic [4:0] out_hour,
  output logic [5:0] out_min,
  output logic [5:0] out_sec,
  output logic       running,
  output logic       borrow_min,
  output logic       borrow_hour,
  output logic       done
);

  localparam int unsigned HW = 5;
  localparam int unsigned MW = 6;
  localparam int unsigned SW = 6;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [HW-1:0] HOUR_MAX = HW'(MAX_HOUR);
  localparam logic [MW-1:0] MIN_MAX  = MW'(MAX_MIN);
  localparam logic [SW-1:0] SEC_MAX  = SW'(MAX_SEC);

  logic [1:0]    r_state;
  logic [HW-1:0] r_hour;
  logic [MW-1:0] r_min;
  logic [SW-1:0] r_sec;
  logic          r_running;
  logic          r_borrow_min;
  logic          r_borrow_hour;
  logic          r_done;

  logic [1:0]    w_state_nxt;
  logic [HW-1:0] w_hour_nxt;
  logic [MW-1:0] w_min_nxt;
  logic [SW-1:0] w_sec_nxt;
  logic          w_borrow_min_nxt;
  logic          w_borrow_hour_nxt;
  logic          w_done_nxt;
  logic          w_nonzero;

  assign w_nonzero = (r_hour != '0) || (r_min != '0) || (r_sec != '0);

  // State and datapath registers; all outputs come straight from here.
  always_ff @(posedge clk_1Hz or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_hour        <= '0;
      r_min         <= '0;
      r_sec         <= '0;
      r_running     <= 1'b0;
      r_borrow_min  <= 1'b0;
      r_borrow_hour <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_hour        <= w_hour_nxt;
      r_min         <= w_min_nxt;
      r_sec         <= w_sec_nxt;
      r_running     <= (w_state_nxt == ST_RUN);
      r_borrow_min  <= w_borrow_min_nxt;
      r_borrow_hour <= w_borrow_hour_nxt;
      r_done        <= w_done_nxt;
    end
  end

  // Next state and next value: load > stop > start, decrement with borrow in RUN.
  always_comb begin
    w_state_nxt       = r_state;
    w_hour_nxt        = r_hour;
    w_min_nxt         = r_min;
    w_sec_nxt         = r_sec;
    w_borrow_min_nxt  = 1'b0;
    w_borrow_hour_nxt = 1'b0;
    w_done_nxt        = 1'b0;
    if (load) begin
      w_state_nxt = ST_IDLE;
      w_hour_nxt  = (load_hour > HOUR_MAX) ? HOUR_MAX : load_hour;
      w_min_nxt   = (load_min  > MIN_MAX)  ? MIN_MAX  : load_min;
      w_sec_nxt   = (load_sec  > SEC_MAX)  ? SEC_MAX  : load_sec;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // A zero preset cannot be started; stop outranks start.
          if (!stop && start && w_nonzero) w_state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (stop) begin
            w_state_nxt = ST_PAUSE;
          end else if (r_sec != '0) begin
            w_sec_nxt = r_sec - SW'(1);
          end else if (r_min != '0) begin
            w_sec_nxt        = SEC_MAX;
            w_min_nxt        = r_min - MW'(1);
            w_borrow_min_nxt = 1'b1;
          end else if (r_hour != '0) begin
            w_sec_nxt         = SEC_MAX;
            w_min_nxt         = MIN_MAX;
            w_hour_nxt        = r_hour - HW'(1);
            w_borrow_min_nxt  = 1'b1;
            w_borrow_hour_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
          end
        end
        ST_PAUSE: begin
          if (!stop && start) w_state_nxt = ST_RUN;
        end
        ST_DONE: begin
          w_state_nxt = ST_IDLE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign out_hour    = r_hour;
  assign out_min     = r_min;
  assign out_sec     = r_sec;
  assign running     = r_running;
  assign borrow_min  = r_borrow_min;
  assign borrow_hour = r_borrow_hour;
  assign done        = r_done;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed testbench for countdown_timer with hand-computed expectations.
module tb_countdown_timer;

  logic       clk_1Hz;
  logic       rst;
  logic       load;
  logic [4:0] load_hour;
  logic [5:0] load_min;
  logic [5:0] load_sec;
  logic       start;
  logic       stop;
  logic [4:0] out_hour;
  logic [5:0] out_min;
  logic [5:0] out_sec;
  logic       running;
  logic       borrow_min;
  logic       borrow_hour;
  logic       done;

  int errors;
  int checks;

  countdown_timer dut (
    .clk_1Hz    (clk_1Hz),
    .rst        (rst),
    .load       (load),
    .load_hour  (load_hour),
    .load_min   (load_min),
    .load_sec   (load_sec),
    .start      (start),
    .stop       (stop),
    .out_hour   (out_hour),
    .out_min    (out_min),
    .out_sec    (out_sec),
    .running    (running),
    .borrow_min (borrow_min),
    .borrow_hour(borrow_hour),
    .done       (done)
  );

  initial clk_1Hz = 1'b0;
  always #5 clk_1Hz = ~clk_1Hz;

  // Advance one active edge, then settle before sampling or driving.
  task automatic step();
    @(posedge clk_1Hz);
    #1;
  endtask

  // Load a preset on the next edge, leaving all controls low afterwards.
  task automatic do_load(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    load = 1'b1; load_hour = h; load_min = m; load_sec = s;
    step();
    load = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({out_hour, out_min, out_sec} !== 17'd0) begin
      errors++; $display("FAIL reset_value: got %0d:%0d:%0d want 0:0:0", out_hour, out_min, out_sec);
    end
    checks++;
    if ({running, borrow_min, borrow_hour, done} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b want 0000", {running, borrow_min, borrow_hour, done});
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic_expiry();
    do_load(5'd0, 6'd0, 6'd2);
    start = 1'b1;
    step(); // E0
    start = 1'b0;
    checks++;
    if (out_sec !== 6'd2 || running !== 1'b1) begin
      errors++; $display("FAIL basic_E0: got sec=%0d run=%b want sec=2 run=1", out_sec, running);
    end
    step(); // E1
    checks++;
    if (out_sec !== 6'd1) begin
      errors++; $display("FAIL basic_E1: got sec=%0d want 1", out_sec);
    end
    step(); // E2
    checks++;
    if (out_sec !== 6'd0 || done !== 1'b0 || running !== 1'b1) begin
      errors++; $display("FAIL basic_E2: got sec=%0d done=%b run=%b want 0 0 1", out_sec, done, running);
    end
    step(); // E3
    checks++;
    if (done !== 1'b1 || running !== 1'b0) begin
      errors++; $display("FAIL basic_E3: got done=%b run=%b want 1 0", done, running);
    end
    start = 1'b1; // ignored in DONE
    step(); // E4
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || running !== 1'b0 || out_sec !== 6'd0) begin
      errors++; $display("FAIL basic_E4: got done=%b run=%b sec=%0d want 0 0 0", done, running, out_sec);
    end
    step();
    checks++;
    if (running !== 1'b0) begin
      errors++; $display("FAIL basic_idle: got run=%b want 0", running);
    end
  endtask

  task automatic test_borrow_min();
    do_load(5'd0, 6'd1, 6'd0);
    start = 1'b1;
    step(); // E0
    start = 1'b0;
    step(); // E1
    checks++;
    if ({out_hour, out_min, out_sec} !== {5'd0, 6'd0, 6'd59} || borrow_min !== 1'b1 || borrow_hour !== 1'b0) begin
      errors++; $display("FAIL borrow_min_E1: got %0d:%0d:%0d bm=%b bh=%b want 0:0:59 1 0",
                         out_hour, out_min, out_sec, borrow_min, borrow_hour);
    end
    step(); // E2
    checks++;
    if (out_sec !== 6'd58 || borrow_min !== 1'b0) begin
      errors++; $display("FAIL borrow_min_E2: got sec=%0d bm=%b want 58 0", out_sec, borrow_min);
    end
  endtask

  task automatic test_borrow_hour();
    do_load(5'd1, 6'd0, 6'd0);
    start = 1'b1;
    step(); // E0
    start = 1'b0;
    checks++;
    if ({out_hour, out_min, out_sec} !== {5'd1, 6'd0, 6'd0}) begin
      errors++; $display("FAIL borrow_hour_E0: got %0d:%0d:%0d want 1:0:0", out_hour, out_min, out_sec);
    end
    step(); // E1
    checks++;
    if ({out_hour, out_min, out_sec} !== {5'd0, 6'd59, 6'd59} || borrow_min !== 1'b1 || borrow_hour !== 1'b1) begin
      errors++; $display("FAIL borrow_hour_E1: got %0d:%0d:%0d bm=%b bh=%b want 0:59:59 1 1",
                         out_hour, out_min, out_sec, borrow_min, borrow_hour);
    end
    step(); // E2
    checks++;
    if (borrow_min !== 1'b0 || borrow_hour !== 1'b0 || out_sec !== 6'd58) begin
      errors++; $display("FAIL borrow_hour_E2: got bm=%b bh=%b sec=%0d want 0 0 58", borrow_min, borrow_hour, out_sec);
    end
  endtask

  task automatic test_pause();
    do_load(5'd0, 6'd0, 6'd5);
    start = 1'b1;
    step(); // E0: 5
    start = 1'b0;
    step(); // E1: 4
    step(); // E2: 3
    stop = 1'b1; start = 1'b1; // stop outranks start
    step(); // E3: PAUSE, 3
    start = 1'b0;
    checks++;
    if (out_sec !== 6'd3 || running !== 1'b0) begin
      errors++; $display("FAIL pause_E3: got sec=%0d run=%b want 3 0", out_sec, running);
    end
    step(); // E4: still PAUSE
    stop = 1'b0;
    checks++;
    if (out_sec !== 6'd3 || running !== 1'b0) begin
      errors++; $display("FAIL pause_E4: got sec=%0d run=%b want 3 0", out_sec, running);
    end
    start = 1'b1;
    step(); // E5: resume, value holds
    start = 1'b0;
    checks++;
    if (out_sec !== 6'd3 || running !== 1'b1) begin
      errors++; $display("FAIL pause_resume: got sec=%0d run=%b want 3 1", out_sec, running);
    end
    step(); // E6
    checks++;
    if (out_sec !== 6'd2) begin
      errors++; $display("FAIL pause_E6: got sec=%0d want 2", out_sec);
    end
    step(); // E7: 1
    step(); // E8: 0
    checks++;
    if (out_sec !== 6'd0 || done !== 1'b0) begin
      errors++; $display("FAIL pause_E8: got sec=%0d done=%b want 0 0", out_sec, done);
    end
    step(); // E9: done
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL pause_done: got done=%b want 1", done);
    end
    step();
  endtask

  task automatic test_clamp_and_zero();
    start = 1'b1; // load outranks start
    do_load(5'd24, 6'd63, 6'd63);
    checks++;
    if ({out_hour, out_min, out_sec} !== {5'd23, 6'd59, 6'd59} || running !== 1'b0) begin
      errors++; $display("FAIL clamp: got %0d:%0d:%0d run=%b want 23:59:59 0",
                         out_hour, out_min, out_sec, running);
    end
    start = 1'b0;
    step();
    checks++;
    if (running !== 1'b0 || out_sec !== 6'd59) begin
      errors++; $display("FAIL load_wins: got run=%b sec=%0d want 0 59", running, out_sec);
    end
    do_load(5'd0, 6'd0, 6'd0);
    start = 1'b1;
    step();
    step();
    start = 1'b0;
    checks++;
    if (running !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL zero_start: got run=%b done=%b want 0 0", running, done);
    end
  endtask

  task automatic test_async_reset();
    do_load(5'd0, 6'd0, 6'd30);
    start = 1'b1;
    step(); // E0: RUN at 00:00:30
    start = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out_hour, out_min, out_sec} !== 17'd0 || running !== 1'b0) begin
      errors++; $display("FAIL async_rst: got %0d:%0d:%0d run=%b want 0:0:0 0",
                         out_hour, out_min, out_sec, running);
    end
    rst = 1'b0;
    start = 1'b1;
    step();
    step();
    start = 1'b0;
    checks++;
    if (running !== 1'b0 || out_sec !== 6'd0) begin
      errors++; $display("FAIL start_after_rst: got run=%b sec=%0d want 0 0", running, out_sec);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1; load = 1'b0; start = 1'b0; stop = 1'b0;
    load_hour = '0; load_min = '0; load_sec = '0;
    #12;
    test_reset();
    test_basic_expiry();
    test_borrow_min();
    test_borrow_hour();
    test_pause();
    test_clamp_and_zero();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
